// File: rtl/uart_pkg.sv
// uart_pkg: bit timing helpers and FSM encoding shared by the UART receiver and transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic int bit_cycles(input int freq_mhz, input int bauds);
        return freq_mhz * 1000000 / bauds;
    endfunction

    function automatic int half_cycles(input int freq_mhz, input int bauds);
        return bit_cycles(freq_mhz, bauds) / 2;
    endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line plus byte consumer handshake of the receiver FIFO
interface uart_rx_fifo_if;
    logic       rx;
    logic       rd;
    logic       valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;
    modport master (output rx, rd, input valid, rx_data, frame_err, overrun);
    modport slave (input rx, rd, output valid, rx_data, frame_err, overrun);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: register-based FIFO with wrap-bit pointers; push on full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2:0] wp, rp;
    logic do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) && (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[DEPTH_LOG2-1:0]];

    // Pointer advance and storage write; reset clears storage so the head reads zero when empty
    always_ff @(posedge clk) begin
        if (!resetq) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[DEPTH_LOG2-1:0]] <= wdata;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver writing complete bytes into a small FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FREQ_MHZ   = 12,
    parameter int BAUDS      = 1200,
    parameter int DEPTH_LOG2 = 2
) (
    input logic           clk,
    input logic           resetq,
    uart_rx_fifo_if.slave bus
);
    localparam int BIT  = bit_cycles(FREQ_MHZ, BAUDS);
    localparam int HALF = half_cycles(FREQ_MHZ, BAUDS);
    localparam int TW   = $clog2(BIT);

    if (BIT < 2) begin : g_bad_bit
        $error("uart_rx_fifo: fewer than 2 clock cycles per bit");
    end

    logic          r0, rs;
    uart_state_t   state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          armed;
    logic          fe_q, ovr_q;
    logic          full, empty;
    logic          expire, stop_ok, pop, push;

    assign expire        = timer == '0;
    assign stop_ok       = state == STOP && expire && rs;
    assign pop           = bus.rd && !empty;
    assign push          = stop_ok && (!full || pop);
    assign bus.valid     = !empty;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ovr_q;

    // Two-flop synchronizer for the asynchronous line, idle high
    always_ff @(posedge clk) begin
        if (!resetq) {r0, rs} <= 2'b11;
        else {r0, rs} <= {bus.rx, r0};
    end

    // Receive FSM; armed records that the line was seen high in IDLE, so a start needs a real falling edge
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
            armed <= 1'b0;
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
            if (state != IDLE && !expire) timer <= timer - 1'b1;
            case (state)
                IDLE: begin
                    armed <= rs;
                    if (armed && !rs) begin
                        timer <= TW'(HALF - 1);
                        state <= START;
                    end
                end
                START: if (expire) begin
                    if (rs) state <= IDLE;
                    else begin
                        timer <= TW'(BIT - 1);
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: if (expire) begin
                    shreg[idx] <= rs;
                    idx        <= idx + 1'b1;
                    timer      <= TW'(BIT - 1);
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (expire) begin
                    state <= IDLE;
                    fe_q  <= !rs;
                    ovr_q <= rs && !push;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .resetq(resetq),
        .push  (push),
        .pop   (pop),
        .wdata (shreg),
        .rdata (bus.rx_data),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench driving 8N1 frames and checking popped bytes and error pulses
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int BIT = 12;

    logic clk = 1'b0;
    logic resetq = 1'b0;
    int n_tests = 0, n_fail = 0;
    int fe_cnt = 0, ovr_cnt = 0, exp_fe = 0, exp_ovr = 0;
    logic [7:0] q[$];

    uart_rx_fifo_if u_if();

    uart_rx_fifo #(.FREQ_MHZ(12), .BAUDS(1000000), .DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .resetq(resetq),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Count error pulse cycles so a stuck or doubled pulse shows up in the totals
    always @(negedge clk) begin
        if (u_if.frame_err) fe_cnt++;
        if (u_if.overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame plus one idle bit; iteration c runs at the c-th negedge, stop bit is sampled at posedge 117
    task automatic send(input logic [7:0] d, input logic stop, input logic pop_at_stop, input int rst_at,
                        output logic v116, output logic v117);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        v116 = 1'b0;
        v117 = 1'b0;
        for (int c = 0; c < 11 * BIT; c++) begin
            u_if.rx = (c < 10 * BIT) ? frame[c / BIT] : 1'b1;
            resetq = (c != rst_at);
            if (c == rst_at) q.delete();
            if (c == 116) begin
                v116 = u_if.valid;
                if (pop_at_stop) begin
                    check("pop_at_stop", u_if.rx_data, q[0]);
                    void'(q.pop_front());
                    u_if.rd = 1'b1;
                end
            end
            if (c == 117) begin
                v117 = u_if.valid;
                u_if.rd = 1'b0;
                if (rst_at < 0) begin
                    if (!stop) exp_fe++;
                    else if (q.size() < 4) q.push_back(d);
                    else exp_ovr++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (!u_if.valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() == 0) check({tag, "_unexpected"}, u_if.valid, 0);
        else if (!u_if.valid) check({tag, "_timeout"}, u_if.valid, 1);
        else begin
            check(tag, u_if.rx_data, q.pop_front());
            u_if.rd = 1'b1;
            @(negedge clk);
            u_if.rd = 1'b0;
        end
    endtask

    initial begin
        logic v1, v2;
        u_if.rx = 1'b1;
        u_if.rd = 1'b0;
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", u_if.valid, 0);
        check("rst_data", u_if.rx_data, 8'h00);
        check("rst_fe", u_if.frame_err, 0);
        check("rst_ovr", u_if.overrun, 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        resetq = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1, 1'b0, -1, v1, v2);
        check("a5_valid_at_sample", v1, 0);
        check("a5_valid_after", v2, 1);
        drain("a5_data");
        check("a5_popped", u_if.valid, 0);

        u_if.rx = 1'b0;
        repeat (4) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_valid", u_if.valid, 0);
        check("glitch_fe", fe_cnt, exp_fe);

        send(8'h3C, 1'b0, 1'b0, -1, v1, v2);
        check("fe_count", fe_cnt, exp_fe);
        check("fe_valid", u_if.valid, 0);
        send(8'h42, 1'b1, 1'b0, -1, v1, v2);
        drain("fe_next_data");
        check("fe_count_after", fe_cnt, exp_fe);

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, -1, v1, v2);
        check("ovr_count", ovr_cnt, exp_ovr);
        check("ovr_valid", u_if.valid, 1);
        repeat (4) drain("ovr_data");
        check("ovr_empty", u_if.valid, 0);

        for (int i = 16; i < 20; i++) send(8'(i), 1'b1, 1'b0, -1, v1, v2);
        send(8'h77, 1'b1, 1'b1, -1, v1, v2);
        check("full_pop_ovr", ovr_cnt, exp_ovr);
        repeat (4) drain("full_pop_data");
        check("full_pop_empty", u_if.valid, 0);

        send(8'hFF, 1'b1, 1'b0, 52, v1, v2);
        check("midrst_valid", u_if.valid, 0);
        send(8'h81, 1'b1, 1'b0, -1, v1, v2);
        drain("midrst_next_data");
        check("midrst_empty", u_if.valid, 0);

        check("final_fe", fe_cnt, exp_fe);
        check("final_ovr", ovr_cnt, exp_ovr);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FREQ_MHZ, default 12, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUDS, default 1200, line bit rate.
REQ-003 SHALL have parameter DEPTH_LOG2, default 2, giving a FIFO depth of 2^DEPTH_LOG2 bytes.
REQ-004 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-005 SHALL have port resetq, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1 LSB first.
REQ-007 SHALL have port rd, input, 1, one-cycle pop strobe from the consumer.
REQ-008 SHALL have port valid, output, 1, high while the FIFO is non-empty.
REQ-009 SHALL have port rx_data, output, 8, the FIFO head byte, meaningful only while valid is high.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-012 SHALL define BIT = FREQ_MHZ*1000000/BAUDS cycles per bit (integer), and HALF = BIT/2.
REQ-013 SHALL pass rx through a two-flop synchronizer, reset to 1; all decoding uses the synchronized value rs.
REQ-014 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE with a bit-timer counter and a 3-bit bit index.
REQ-015 In IDLE, rs low SHALL load the timer with HALF-1 and enter START.
REQ-016 In START, when the timer expires, rs high SHALL return to IDLE (glitch rejected, nothing stored); rs low SHALL load the timer with BIT-1, clear the bit index, and enter DATA.
REQ-017 In DATA, each timer expiry SHALL shift rs into the shift register at bit[index], reload BIT-1, and increment the index; expiry at index 7 SHALL enter STOP.
REQ-018 In STOP, when the timer expires with rs high and the FIFO not full, the byte SHALL be written to the FIFO.
REQ-019 In STOP, when the timer expires with rs high and the FIFO full, the byte SHALL be dropped, overrun SHALL pulse, and the FIFO SHALL be unchanged.
REQ-020 In STOP, when the timer expires with rs low, the byte SHALL be dropped and frame_err SHALL pulse.
REQ-021 Every STOP timer expiry SHALL return to IDLE on the next cycle, regardless of outcome.
REQ-022 After a framing error, a byte is only accepted once rs goes high and then falls again.
REQ-023 Latency: valid SHALL rise one cycle after the stop-bit sample.
REQ-024 rx_data SHALL be driven from the registered read pointer, so the same byte is presented until it is popped.
REQ-025 rd while valid is high SHALL advance the read pointer by one; rd while empty SHALL be ignored.
REQ-026 A push and a pop in the same cycle SHALL leave the count unchanged and are legal when full.
REQ-027 A push on a full FIFO with a pop in the same cycle SHALL NOT count as overrun.
REQ-028 Pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
REQ-029 The FIFO is empty when the pointers are equal, and full when the MSBs differ and the remaining bits are equal.
REQ-030 The bit-timer width SHALL be $clog2(BIT), and BIT < 2 SHALL be a synthesis-time error.

Reset
REQ-031 resetq low SHALL, at the next edge, set the state to IDLE, clear both pointers (valid=0), set the synchronizer to 1, and clear the timer, index, frame_err and overrun.
REQ-032 rx_data SHALL read 8'h00 while empty after reset.
REQ-033 Reset asserted mid-frame SHALL discard the partial byte; after release, the first byte is received only when rx is next seen high followed by a falling edge.

Structure
REQ-034 BIT/HALF computation and the FSM state encoding SHALL live in the shared package uart_pkg, for reuse by the transmitter.
REQ-035 The FIFO SHALL be the sub-module sync_fifo (parameterized width/depth, push/pop/full/empty), memory inferred as registers.

Verification (FREQ_MHZ=12, BAUDS=1000000, giving BIT=12)
REQ-036 Send 0xA5: valid rises 1 cycle after the stop sample and rx_data=0xA5; rd pulse gives valid=0.
REQ-037 A 4-cycle low glitch on idle rx: no write, state returns to IDLE, valid stays 0.
REQ-038 0x3C sent with the stop bit held low: frame_err pulses once, valid stays 0; a following 0x42 is received correctly.
REQ-039 Five bytes 0x01..0x05 sent with no rd: FIFO holds 0x01..0x04, overrun pulses once on 0x05; four pops return 0x01..0x04 in order.
REQ-040 FIFO full, rd asserted on the exact stop-sample cycle of 0x77: no overrun, count stays 4, 0x77 is popped last.
REQ-041 resetq low for 1 cycle during bit 3 of 0xFF: no write; a subsequent 0x81 is received correctly.
